// File: rtl/text_banner_render.sv
// -----------------------------------------------------------------------------
// text_banner_render
//
// Overlays a 210x25 one-bit text banner on a VGA pixel stream. The banner
// bitmap comes from an external combinational ROM, one 210-bit row per
// address. Pixels pass through a two-stage pipeline that only advances on
// pixel_tick. Stage 1 works out the window position and the ROM row. Stage 2
// picks the bit for the column and registers the RGB332 colour.
// An optional blink mode alternates the banner between visible and hidden
// every 64 frames.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   pixel_tick  one-clk pixel enable from the sync generator
//   video_on    high in the visible area
//   pixel_x     current column, 0..799
//   pixel_y     current row, 0..524
//   blink_en    enables 64-frame blinking of the banner
//   rom_addr    registered row address to the text ROM (0..24)
//   rom_data    ROM row, bit 209 = leftmost banner column
//   rgb         registered RGB332 output pixel
// -----------------------------------------------------------------------------
module text_banner_render #(
   parameter int unsigned X0 = 215,
   parameter int unsigned Y0 = 40,
   parameter logic [7:0]  FG = 8'hFF,
   parameter logic [7:0]  BG = 8'h00
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           pixel_tick,
   input  logic           video_on,
   input  logic [9:0]     pixel_x,
   input  logic [9:0]     pixel_y,
   input  logic           blink_en,
   output logic [7:0]     rom_addr,
   input  logic [209:0]   rom_data,
   output logic [7:0]     rgb
);

   localparam logic [9:0] X_LO = 10'(X0);
   localparam logic [9:0] X_HI = 10'(X0 + 32'd209);
   localparam logic [9:0] Y_LO = 10'(Y0);
   localparam logic [9:0] Y_HI = 10'(Y0 + 32'd24);

   typedef enum logic {
      SHOW = 1'b0,
      HIDE = 1'b1
   } vis_state_e;

   vis_state_e state_q, state_d;

   logic [7:0] rom_addr_q, rom_addr_d;
   logic [7:0] col_q, col_d;
   logic       in_win_q, in_win_d;
   logic       von_q, von_d;
   logic [7:0] rgb_q, rgb_d;
   logic [5:0] frame_cnt_q, frame_cnt_d;

   logic       in_win_s;
   logic       frame_tick_s;
   logic [7:0] bit_idx_s;
   logic       bit_sel_s;

   // Stage 1: window test, ROM row address and column offset
   always_comb begin
      in_win_s   = (pixel_x >= X_LO) && (pixel_x <= X_HI) &&
                   (pixel_y >= Y_LO) && (pixel_y <= Y_HI);
      rom_addr_d = rom_addr_q;
      col_d      = col_q;
      in_win_d   = in_win_q;
      von_d      = von_q;
      if (pixel_tick) begin
         col_d    = 8'(pixel_x - X_LO);
         in_win_d = in_win_s;
         von_d    = video_on;
         // Outside the window the address holds, so the ROM output stays stable.
         if (in_win_s) begin
            rom_addr_d = 8'(pixel_y - Y_LO);
         end else begin
            rom_addr_d = rom_addr_q;
         end
      end else begin
         rom_addr_d = rom_addr_q;
      end
   end

   // Stage 2: select the banner bit for this column and form the colour
   always_comb begin
      bit_idx_s = 8'd209 - col_q;
      // col_q is only meaningful in-window; guard the index for other pixels
      if (col_q <= 8'd209) begin
         bit_sel_s = rom_data[bit_idx_s];
      end else begin
         bit_sel_s = 1'b0;
      end
      rgb_d = rgb_q;
      if (pixel_tick) begin
         if (!von_q) begin
            rgb_d = 8'h00;
         end else if (in_win_q && bit_sel_s && (state_q == SHOW)) begin
            rgb_d = FG;
         end else begin
            rgb_d = BG;
         end
      end else begin
         rgb_d = rgb_q;
      end
   end

   // Frame counter and SHOW/HIDE next-state logic
   always_comb begin
      frame_tick_s = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);
      frame_cnt_d  = frame_cnt_q;
      state_d      = state_q;
      if (frame_tick_s) begin
         frame_cnt_d = frame_cnt_q + 6'd1;
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
      // Toggling happens only on the wrapping frame tick, so it always
      // lands on a frame boundary.
      if (!blink_en) begin
         state_d = SHOW;
      end else if (frame_tick_s && (frame_cnt_q == 6'd63)) begin
         case (state_q)
            SHOW:    state_d = HIDE;
            HIDE:    state_d = SHOW;
            default: state_d = SHOW;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Pipeline, frame counter and FSM state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rom_addr_q  <= 8'h00;
         col_q       <= 8'h00;
         in_win_q    <= 1'b0;
         von_q       <= 1'b0;
         rgb_q       <= 8'h00;
         frame_cnt_q <= 6'd0;
         state_q     <= SHOW;
      end else begin
         rom_addr_q  <= rom_addr_d;
         col_q       <= col_d;
         in_win_q    <= in_win_d;
         von_q       <= von_d;
         rgb_q       <= rgb_d;
         frame_cnt_q <= frame_cnt_d;
         state_q     <= state_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign rgb      = rgb_q;

endmodule
